// File: rtl/outport_out_interface.sv
// Output-side stage: round-robin arbitration among requesting inports, packet-long grant hold,
// one-entry output register to the link. Define OUTPORT_PKT_CNT_EN to add the pkt_count output.
module outport_out_interface #(
    parameter int unsigned no_inport                   = 6,
    parameter int unsigned floorplusone_log2_no_inport = 3,
    parameter int unsigned phit_size                   = 16
) (
    input  logic                           clk,
    input  logic                           rs,
    input  logic [no_inport*phit_size-1:0] indatas,
    input  logic [no_inport-1:0]           in_sent_req_vec,
    input  logic [no_inport-1:0]           in_new_vec,
    output logic [no_inport-1:0]           calls,
    output logic [no_inport-1:0]           ready_vec,
    output logic [phit_size-1:0]           outdata,
    output logic                           out_new,
    output logic                           out_sent_req,
    input  logic                           down_full,
    input  logic                           down_pre_full,
    output logic                           busy
`ifdef OUTPORT_PKT_CNT_EN
    ,
    output logic [15:0]                    pkt_count
`endif
);

    localparam int unsigned PW = floorplusone_log2_no_inport;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        XFER  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                state, state_nx;
    logic [PW-1:0]         rr_ptr, rr_ptr_nx;
    logic [PW-1:0]         grant, grant_nx;
    logic [PW-1:0]         arb_idx, scan_idx;
    logic                  arb_found;
    logic                  accept;
    logic [no_inport-1:0]  grant_oh;
    logic [phit_size-1:0]  sel_data;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        return (v == PW'(no_inport - 1)) ? '0 : v + PW'(1);
    endfunction

    // Scan once around the ring starting at rr_ptr; first requester wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        scan_idx  = rr_ptr;
        for (int unsigned k = 0; k < no_inport; k++) begin
            if (!arb_found && in_sent_req_vec[scan_idx]) begin
                arb_found = 1'b1;
                arb_idx   = scan_idx;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    always_comb begin
        grant_oh        = '0;
        grant_oh[grant] = 1'b1;
        sel_data        = '0;
        for (int unsigned i = 0; i < no_inport; i++) begin
            if (grant == PW'(i)) begin
                sel_data = indatas[i*phit_size +: phit_size];
            end
        end
    end

    always_comb begin
        state_nx  = state;
        grant_nx  = grant;
        rr_ptr_nx = rr_ptr;
        calls     = '0;
        ready_vec = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (|in_sent_req_vec) begin
                    state_nx = ARB;
                end
            end
            ARB: begin
                if (arb_found) begin
                    grant_nx = arb_idx;
                    state_nx = XFER;
                end else begin
                    state_nx = IDLE;
                end
            end
            XFER: begin
                calls = grant_oh;
                // A phit sitting in the output register plus pre_full means the last
                // downstream slot is already spoken for.
                if (!down_full && !(down_pre_full && out_new)) begin
                    ready_vec = grant_oh;
                end
                accept = |(in_new_vec & ready_vec);
                if (!in_sent_req_vec[grant]) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                rr_ptr_nx = wrap_inc(grant);
                state_nx  = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant        <= '0;
            outdata      <= '0;
            out_new      <= 1'b0;
            out_sent_req <= 1'b0;
        end else begin
            state   <= state_nx;
            rr_ptr  <= rr_ptr_nx;
            grant   <= grant_nx;
            out_new <= accept;
            if (accept) begin
                outdata <= sel_data;
            end
            if (accept) begin
                out_sent_req <= 1'b1;
            end else if (state == DRAIN) begin
                out_sent_req <= 1'b0;
            end
        end
    end

`ifdef OUTPORT_PKT_CNT_EN
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            pkt_count <= '0;
        end else if (state == XFER && state_nx == DRAIN) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/outport_out_interface.md
Name: outport_out_interface

Overview:
- Output-side stage that sits directly downstream of each input port's inport interface.
- Arbitrates round-robin among input ports requesting this outport and holds the grant for the whole packet.
- Forwards phits through a one-entry output register onto the link toward the next router's input interface.
- Honours downstream full/pre_full back-pressure.

Parameters:
no_inport, 6, number of input ports that can request this outport
floorplusone_log2_no_inport, 3, width of the round-robin pointer / grant index
phit_size, 16, link data width in bits

Ports:
clk  input  1  system clock, rising edge
rs  input  1  asynchronous active-low reset
indatas  input  no_inport*phit_size  phit from each inport; slice i = bits [(i+1)*phit_size-1 : i*phit_size]
in_sent_req_vec  input  no_inport  bit i high while inport i has a packet for this outport; held through tail phit
in_new_vec  input  no_inport  bit i pulses one cycle per valid phit from inport i
calls  output  no_inport  one-hot grant; bit g high for the whole packet of winner g
ready_vec  output  no_inport  bit g high when the outport accepts a phit from g this cycle
outdata  output  phit_size  registered phit to the link
out_new  output  1  one-cycle valid pulse per phit on outdata
out_sent_req  output  1  high from first phit launch until the packet is released
down_full  input  1  downstream buffer full
down_pre_full  input  1  downstream buffer has exactly one free slot
busy  output  1  state != IDLE

Behaviour:
- Reset (rs=0, asynchronous) forces:
  - state=IDLE, rr_ptr=0
  - calls=0, ready_vec=0, outdata=0, out_new=0, out_sent_req=0, busy=0
- States: IDLE, ARB, XFER, DRAIN.
- IDLE -> ARB when |in_sent_req_vec.
- ARB, one cycle:
  - Pick the first requester starting at rr_ptr, wrapping modulo no_inport.
  - Register its index g and set calls[g].
  - Go to XFER.
  - If the request vanished in the meantime, return to IDLE with calls=0.
- XFER:
  - Combinational: ready_vec[g] = !down_full && !(down_pre_full && out_new); all other ready bits are 0.
  - A phit is accepted when in_new_vec[g] && ready_vec[g].
  - Accept latency is 1 cycle: outdata <= indatas slice g, out_new=1 for exactly one cycle.
  - out_sent_req is set on the first accept and stays high.
  - in_new_vec[g] with ready low: phit is not captured; the inport holds data and retries.
  - in_new on non-granted bits is ignored.
- Release:
  - in_sent_req_vec[g] falls while in XFER -> DRAIN.
  - A phit accepted in that same cycle is still forwarded.
- DRAIN, one cycle:
  - calls=0, ready_vec=0.
  - Output register completes its pulse; out_sent_req clears at the end of DRAIN.
  - rr_ptr <= (g+1) mod no_inport, wrapping from no_inport-1 to 0.
  - Go to IDLE.
- Back-to-back packets: the minimum gap is IDLE+ARB, i.e. 2 cycles between release and the next grant.
- down_full asserted mid-packet stalls acceptance indefinitely; grant is kept and no phit is dropped.
- down_pre_full with a phit already in the output register blocks one further accept; this prevents overrun of the last slot.
- Reset mid-packet: everything returns to its reset value immediately; a partial packet is abandoned and upstream must reissue.

Optional Feature:
- OUTPORT_PKT_CNT_EN defined:
  - Adds output pkt_count [15:0], reset 0.
  - Increments by 1 on every XFER->DRAIN transition; wraps 16'hFFFF -> 0.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Single packet: reset, then in_sent_req_vec=6'b000100 with 3 phits 16'hA001/A002/A003 on slot 2, down_full=0.
  - ARB cycle, then calls=6'b000100.
  - outdata shows A001..A003 each one cycle after its in_new, with out_new pulses.
  - DRAIN, IDLE; rr_ptr=3.
- Round-robin fairness: inports 0 and 5 request continuously, 1-phit packets, rr_ptr=0.
  - Grants alternate 0,5,0,5.
  - Exactly 2 idle cycles between each release and the next grant.
- Back-pressure: during XFER raise down_full for 4 cycles.
  - ready_vec=0 and no out_new for those 4 cycles.
  - After lowering, the held phit 16'hBEEF appears exactly once.
- Pre-full: down_pre_full=1 with out_new high.
  - Next accept is blocked one cycle even though in_new_vec[g]=1.
  - No phit lost; total out_new count equals phits sent.
- Reset mid-packet: assert rs=0 after 2 of 5 phits.
  - calls, ready_vec, out_new, out_sent_req are 0 asynchronously (before next clk).
  - After release, IDLE and rr_ptr=0.
- OUTPORT_PKT_CNT_EN: send 3 packets -> pkt_count=3. Preload 16'hFFFF and send one packet -> pkt_count=0.
